// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory arbiter.
// State encoding and the per-requester request bundle.
package mem_arb_pkg;

   localparam int MEM_AW = 8;
   localparam int MEM_DW = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic              req;
      logic              we;
      logic [MEM_AW-1:0] addr;
      logic [MEM_DW-1:0] wdata;
   } req_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin winner select.
// On contention the requester named by rr_ptr_i wins.
module rr_pick2 (
   input  logic req0_i,
   input  logic req1_i,
   input  logic rr_ptr_i,
   output logic any_o,
   output logic win_o
);

   assign any_o = req0_i | req1_i;
   assign win_o = (req0_i & req1_i) ? rr_ptr_i : req1_i;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the 256x16 single-port memory.
// Registered grants, bounded hold, 1-cycle read return.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW       = MEM_AW,
   parameter int DW       = MEM_DW,
   parameter int MAX_HOLD = 4
) (
   input  logic          ck,
   input  logic          rst,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          gnt0,
   output logic          rvalid0,
   output logic [DW-1:0] rdata0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          gnt1,
   output logic          rvalid1,
   output logic [DW-1:0] rdata1,
   output logic          mem_ce,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

   arb_state_t    state_q;
   logic          rr_q;
   logic [HW-1:0] hold_q;
   logic          rvalid0_q;
   logic          rvalid1_q;
   logic [DW-1:0] rdata0_q;
   logic [DW-1:0] rdata1_q;

   req_t r0;
   req_t r1;
   req_t own;
   logic own1;
   logic acc;
   logic other_req;
   logic pick_any;
   logic pick_win;

   assign r0 = '{req: req0, we: we0, addr: addr0, wdata: wdata0};
   assign r1 = '{req: req1, we: we1, addr: addr1, wdata: wdata1};

   assign own1      = (state_q == OWN1);
   assign own       = own1 ? r1 : r0;
   assign acc       = (state_q != IDLE) & own.req;
   assign other_req = own1 ? req0 : req1;

   assign gnt0    = (state_q == OWN0);
   assign gnt1    = own1;
   assign rvalid0 = rvalid0_q;
   assign rvalid1 = rvalid1_q;
   assign rdata0  = rdata0_q;
   assign rdata1  = rdata1_q;

   // Idle keeps the bus at zero; an owner steers its own fields.
   assign mem_ce    = acc;
   assign mem_we    = acc & own.we;
   assign mem_addr  = (state_q == IDLE) ? '0 : own.addr;
   assign mem_wdata = (state_q == IDLE) ? '0 : own.wdata;

   rr_pick2 u_pick (
      .req0_i  (req0),
      .req1_i  (req1),
      .rr_ptr_i(rr_q),
      .any_o   (pick_any),
      .win_o   (pick_win)
   );

   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         rr_q      <= 1'b0;
         hold_q    <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (pick_any)
                  state_q <= pick_win ? OWN1 : OWN0;
            end
            OWN0, OWN1: begin
               if (acc && !own.we) begin
                  if (own1) begin
                     rdata1_q  <= mem_rdata;
                     rvalid1_q <= 1'b1;
                  end else begin
                     rdata0_q  <= mem_rdata;
                     rvalid0_q <= 1'b1;
                  end
               end
               if (!own.req) begin
                  hold_q  <= '0;
                  rr_q    <= ~own1;
                  state_q <= other_req ? (own1 ? OWN0 : OWN1) : IDLE;
               end else if (hold_q == HOLD_LAST) begin
                  // Burst limit: only yield if someone is waiting.
                  hold_q <= '0;
                  if (other_req) begin
                     state_q <= own1 ? OWN0 : OWN1;
                     rr_q    <= own1;
                  end
               end else begin
                  hold_q <= hold_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256x16 memory.
// Vector table plus fairness, burst, and async-reset sequences.
module tb_mem_arbiter;

   logic        ck;
   logic        rst;
   logic        req0, we0, req1, we1;
   logic [7:0]  addr0, addr1;
   logic [15:0] wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1;
   logic [15:0] rdata0, rdata1;
   logic        mem_ce, mem_we;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata, mem_rdata;

   logic [15:0] mem [256];

   int n_cmp = 0;
   int n_bad = 0;

   mem_arbiter dut (
      .ck       (ck),
      .rst      (rst),
      .req0     (req0),
      .we0      (we0),
      .addr0    (addr0),
      .wdata0   (wdata0),
      .gnt0     (gnt0),
      .rvalid0  (rvalid0),
      .rdata0   (rdata0),
      .req1     (req1),
      .we1      (we1),
      .addr1    (addr1),
      .wdata1   (wdata1),
      .gnt1     (gnt1),
      .rvalid1  (rvalid1),
      .rdata1   (rdata1),
      .mem_ce   (mem_ce),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   assign mem_rdata = mem[mem_addr];
   always @(posedge ck)
      if (mem_ce && mem_we) mem[mem_addr] <= mem_wdata;

   always @(negedge ck) begin
      n_cmp++;
      if (gnt0 && gnt1) begin
         n_bad++;
         $display("FAIL excl: gnt0=%b gnt1=%b both high", gnt0, gnt1);
      end
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic r0, w0; logic [7:0] a0; logic [15:0] d0;
      logic r1, w1; logic [7:0] a1; logic [15:0] d1;
      logic g0, g1, v0, v1, ce, we;
      logic [7:0] a; logic [15:0] rd0, rd1;
   } vec_t;

   function automatic vec_t mk(
      logic r0, logic w0, logic [7:0] a0, logic [15:0] d0,
      logic r1, logic w1, logic [7:0] a1, logic [15:0] d1,
      logic g0, logic g1, logic v0, logic v1,
      logic ce, logic we, logic [7:0] a,
      logic [15:0] rd0, logic [15:0] rd1);
      vec_t v;
      v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
      v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1;
      v.ce = ce; v.we = we; v.a = a;
      v.rd0 = rd0; v.rd1 = rd1;
      return v;
   endfunction

   task automatic idle_inputs();
      req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
      req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
   endtask

   task automatic do_reset();
      @(negedge ck);
      rst = 0;
      idle_inputs();
      repeat (2) @(negedge ck);
      rst = 1;
   endtask

   initial begin
      vec_t tbl[$];
      logic [63:0] act, exp;
      int own_k, own_p;

      for (int i = 0; i < 256; i++) mem[i] = 16'h0;
      mem[9]  = 16'h000A;
      mem[30] = 16'hBEEF;

      // reset with both requesting
      idle_inputs();
      rst = 0; req0 = 1; req1 = 1;
      repeat (2) @(negedge ck);
      #1;
      chk("rst_outs", {gnt0, gnt1, rvalid0, rvalid1, mem_ce, mem_we},
          6'b0);
      chk("rst_bus", {mem_addr, mem_wdata, rdata0, rdata1}, 56'h0);
      rst = 1;
      @(negedge ck); #1;
      chk("rst_rel_gnt", {gnt0, gnt1}, 2'b10);

      tbl.push_back(mk(1,0,9,0,     0,0,0,0,
                       0,0,0,0, 0,0,0,  16'h0, 16'h0));
      tbl.push_back(mk(1,0,9,0,     0,0,0,0,
                       1,0,0,0, 1,0,9,  16'h0, 16'h0));
      tbl.push_back(mk(0,0,9,0,     0,0,0,0,
                       1,0,1,0, 0,0,9,  16'h000A, 16'h0));
      tbl.push_back(mk(1,0,10,0,    1,1,10,16'h1234,
                       0,0,0,0, 0,0,0,  16'h000A, 16'h0));
      tbl.push_back(mk(1,0,10,0,    1,1,10,16'h1234,
                       0,1,0,0, 1,1,10, 16'h000A, 16'h0));
      tbl.push_back(mk(1,0,10,0,    0,1,10,16'h1234,
                       0,1,0,0, 0,0,10, 16'h000A, 16'h0));
      tbl.push_back(mk(1,0,10,0,    0,0,10,0,
                       1,0,0,0, 1,0,10, 16'h000A, 16'h0));
      tbl.push_back(mk(0,0,10,0,    0,0,10,0,
                       1,0,1,0, 0,0,10, 16'h1234, 16'h0));
      tbl.push_back(mk(0,0,0,0,     0,0,0,0,
                       0,0,0,0, 0,0,0,  16'h1234, 16'h0));

      do_reset();
      for (int i = 0; i < tbl.size(); i++) begin
         if (i > 0) @(negedge ck);
         req0 = tbl[i].r0; we0 = tbl[i].w0;
         addr0 = tbl[i].a0; wdata0 = tbl[i].d0;
         req1 = tbl[i].r1; we1 = tbl[i].w1;
         addr1 = tbl[i].a1; wdata1 = tbl[i].d1;
         #1;
         act = {18'h0, gnt0, gnt1, rvalid0, rvalid1, mem_ce, mem_we,
                mem_addr, rdata0, rdata1};
         exp = {18'h0, tbl[i].g0, tbl[i].g1, tbl[i].v0, tbl[i].v1,
                tbl[i].ce, tbl[i].we, tbl[i].a, tbl[i].rd0, tbl[i].rd1};
         chk($sformatf("vec%0d", i), act, exp);
      end

      // fairness: both read continuously
      do_reset();
      req0 = 1; addr0 = 8'd1; req1 = 1; addr1 = 8'd2;
      #1;
      chk("fair_k0", {gnt0, gnt1}, 2'b00);
      for (int k = 1; k <= 24; k++) begin
         @(negedge ck); #1;
         own_k = ((k - 1) / 4) % 2;
         own_p = ((k - 2) / 4) % 2;
         chk($sformatf("fair_gnt%0d", k), {gnt0, gnt1},
             {own_k == 0, own_k == 1});
         if (k >= 2)
            chk($sformatf("fair_rv%0d", k), {rvalid0, rvalid1},
                {own_p == 0, own_p == 1});
      end

      // hold renewal: requester 1 alone, 10 writes
      do_reset();
      req1 = 1; we1 = 1; addr1 = 8'd20; wdata1 = 16'h5000;
      @(negedge ck);
      for (int i = 0; i < 10; i++) begin
         addr1 = 8'(20 + i);
         wdata1 = 16'(16'h5000 + i);
         #1;
         chk($sformatf("hold_gnt%0d", i), {gnt1, gnt0, mem_ce, mem_we},
             4'b1011);
         @(negedge ck);
      end
      req1 = 0; we1 = 0;
      @(negedge ck);
      for (int i = 0; i < 10; i++)
         chk($sformatf("hold_mem%0d", 20 + i), mem[20 + i],
             64'(16'h5000 + i));

      // async reset in the middle of an owner-1 write burst
      do_reset();
      req1 = 1; we1 = 1; addr1 = 8'd31; wdata1 = 16'h1111;
      @(negedge ck);
      @(negedge ck);
      addr1 = 8'd30; wdata1 = 16'h7777;
      #1;
      chk("ar_pre", {gnt1, mem_ce, mem_we}, 3'b111);
      #2;
      rst = 0;
      #1;
      chk("ar_clr", {gnt0, gnt1, mem_ce, mem_we, rvalid1}, 5'b0);
      @(posedge ck); #1;
      chk("ar_mem30", mem[30], 64'hBEEF);
      chk("ar_mem31", mem[31], 64'h1111);
      @(negedge ck);
      idle_inputs();
      rst = 1;
      @(negedge ck);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter in front of the single-port 256x16 program/data memory.
- Requester 0 is the NanoCPU memory port; requester 1 is a secondary master, such as a loader/DMA that preloads programs or dumps results.
- Provides a registered grant, round-robin fairness with a bounded hold (burst) length, and 1-cycle registered read return per requester.

Parameters:
- AW, 8: address width (256 words).
- DW, 16: data width.
- MAX_HOLD, 4: max consecutive accesses by one owner while the other requester waits (>=1).

Ports:
- ck  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req0  in  1  requester 0 wants an access this cycle.
- we0  in  1  requester 0 write (1) / read (0).
- addr0  in  AW  requester 0 address.
- wdata0  in  DW  requester 0 write data.
- gnt0  out  1  requester 0 owns memory; access accepted when req0&gnt0.
- rvalid0  out  1  read data for requester 0 valid.
- rdata0  out  DW  registered read data for requester 0.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as requester 0, for requester 1.
- mem_ce  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, combinational from mem_addr.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, rr_ptr=0 (requester 0 favoured), hold_cnt=0.
  - gnt0/1=0, rvalid0/1=0, rdata0/1=0.
  - mem_ce=mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset mid-transaction drops it; no write completes after reset asserts.
- FSM states: IDLE, OWN0, OWN1. Grants are decoded from state: gnt0=(state==OWN0), gnt1=(state==OWN1).
- IDLE:
  - No req → stay.
  - One req → OWNx.
  - Both → OWN[rr_ptr].
  - Grant latency from first req in IDLE = 1 cycle.
- OWNx, accepting:
  - acc_x = req_x & gnt_x.
  - On acc_x, memory is driven combinationally this cycle: mem_ce=1, mem_we=we_x, mem_addr=addr_x, mem_wdata=wdata_x.
  - No access → mem_ce=0, mem_we=0; address/wdata fields hold the owner's inputs (don't-care).
- OWNx, on acc_x:
  - hold_cnt increments.
  - For a read (we_x=0): rdata_x <= mem_rdata at the same edge, and rvalid_x=1 for exactly the next cycle. Read latency = 1 cycle.
  - Writes never raise rvalid.
  - rdata_x holds its last value when rvalid_x=0.
- OWNx transitions, evaluated at each edge in priority order:
  - (a) req_x=0 and req_y=1 → OWNy, hold_cnt=0, rr_ptr=y.
  - (b) req_x=0 and req_y=0 → IDLE, hold_cnt=0, rr_ptr=y.
  - (c) acc_x and hold_cnt==MAX_HOLD-1 and req_y=1 → OWNy, hold_cnt=0, rr_ptr=x.
  - (d) acc_x and hold_cnt==MAX_HOLD-1 and req_y=0 → stay OWNx, hold_cnt=0 (no starvation possible, so no forced release).
  - Otherwise stay.
- Direct OWNx→OWNy handover takes zero idle cycles: gnt_y rises on the same edge gnt_x falls.
- Exactly one of gnt0/gnt1 is high, or neither; never both (assertion).
- Worst-case wait for a continuously requesting master is MAX_HOLD accesses.
- Write then read of the same address by different owners in consecutive cycles: the read returns the new data (memory write on edge, combinational read the next cycle).
- hold_cnt width = $clog2(MAX_HOLD+1). It never exceeds MAX_HOLD-1.

Decomposition:
- Package mem_arb_pkg:
  - typedef arb_state_t {IDLE, OWN0, OWN1}.
  - typedef of a requester struct {req, we, addr, wdata}.
  - Localparams AW/DW defaults.
- One sub-module is natural: rr_pick2, a combinational round-robin winner select from {req0, req1, rr_ptr}, reusable if the arbiter grows to N requesters.
- The FSM, counter and read-return registers stay in mem_arbiter.

Test Plan:
- Reset: hold rst=0 for 2 cycles with req0=req1=1 → all gnt/rvalid/mem_ce=0. Release → gnt0=1 one cycle later (rr_ptr=0).
- Single read: requester 0 only, addr0=9, memory[9]=0x000A → gnt0=1 next cycle; mem_ce=1, mem_we=0, mem_addr=9 during accept; rvalid0=1 and rdata0=0x000A the following cycle; rvalid1 stays 0.
- Write then read across owners:
  - Requester 1 writes 0x1234 to addr 10, then drops req1.
  - Requester 0, already requesting, gets gnt0 on the next edge and reads addr 10.
  - Expected: rdata0=0x1234, rvalid0 pulse of 1 cycle.
- Fairness with MAX_HOLD=4: both requesters continuously request reads → grant pattern 4 accesses owner 0, 4 accesses owner 1, repeating, with no idle cycle between owners. gnt0&gnt1 never high together.
- Hold renewal: requester 1 alone requests 10 consecutive writes to addr 20..29 → gnt1 stays high all 10 cycles; memory[20..29] updated; hold_cnt wraps 0..3 without releasing.
- Async reset mid-burst: assert rst=0 between edges during an owner-1 write burst at addr 30 → outputs clear immediately. The write pending at the next edge does not occur; memory[30] is unchanged.
